// File: rtl/mole_game_if.sv
// Button and display bundle between the whack-a-mole round sequencer and its surroundings.
// master: button/display side; slave: the sequencer.
interface mole_game_if #(
  parameter int N_MOLES = 4
);
  logic               start;
  logic [N_MOLES-1:0] whack;
  logic [N_MOLES-1:0] mole_led;
  logic [7:0]         score;
  logic [7:0]         round;
  logic               hit_pulse;
  logic               miss_pulse;
  logic               busy;
  logic               game_over;

  modport master (
    output start, whack,
    input  mole_led, score, round, hit_pulse, miss_pulse, busy, game_over
  );

  modport slave (
    input  start, whack,
    output mole_led, score, round, hit_pulse, miss_pulse, busy, game_over
  );
endinterface

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round sequencer: GAP/SHOW/SCORE pacing, LFSR mole pick,
// hit/miss judging on button rising edges, saturating score and round count.
module mole_game_ctrl #(
  parameter int N_MOLES     = 4,
  parameter int SHOW_CYCLES = 1000,
  parameter int GAP_CYCLES  = 500,
  parameter int ROUNDS      = 16
) (
  input logic         clk,
  input logic         rst_n,
  mole_game_if.slave  bus
);
  localparam int IW   = $clog2(N_MOLES);
  localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC);

  typedef enum logic [2:0] {IDLE, GAP, SHOW, SCORE, DONE} state_t;

  state_t             state_reg;
  logic [TW-1:0]      timer_reg;
  logic [7:0]         lfsr_reg;
  logic               start_q;
  logic [N_MOLES-1:0] whack_q;
  logic [N_MOLES-1:0] mole_led_reg;
  logic [7:0]         score_reg;
  logic [7:0]         round_reg;
  logic               hit_reg;
  logic               miss_reg;
  logic               busy_reg;
  logic               game_over_reg;

  logic               start_e;
  logic [N_MOLES-1:0] whack_e;
  logic               lfsr_fb;
  logic [N_MOLES-1:0] lit_pick;

  assign start_e  = bus.start & ~start_q;
  assign whack_e  = bus.whack & ~whack_q;
  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign lfsr_fb  = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign lit_pick = {{(N_MOLES-1){1'b0}}, 1'b1} << lfsr_reg[IW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      lfsr_reg      <= 8'hA5;
      start_q       <= 1'b1;
      whack_q       <= '1;
      mole_led_reg  <= '0;
      score_reg     <= 8'd0;
      round_reg     <= 8'd0;
      hit_reg       <= 1'b0;
      miss_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      start_q  <= bus.start;
      whack_q  <= bus.whack;
      lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
      hit_reg  <= 1'b0;
      miss_reg <= 1'b0;

      case (state_reg)
        IDLE, DONE: begin
          if (start_e) begin
            state_reg     <= GAP;
            timer_reg     <= '0;
            score_reg     <= 8'd0;
            round_reg     <= 8'd0;
            busy_reg      <= 1'b1;
            game_over_reg <= 1'b0;
          end
        end

        GAP: begin
          if (timer_reg == TW'(GAP_CYCLES - 1)) begin
            state_reg    <= SHOW;
            timer_reg    <= '0;
            mole_led_reg <= lit_pick;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        SHOW: begin
          // An edge in the last SHOW cycle is judged, not treated as a timeout.
          if ((whack_e != '0) || (timer_reg == TW'(SHOW_CYCLES - 1))) begin
            state_reg    <= SCORE;
            mole_led_reg <= '0;
            if (whack_e == mole_led_reg)
              hit_reg <= 1'b1;
            else
              miss_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        SCORE: begin
          if (hit_reg && (score_reg != 8'hFF))
            score_reg <= score_reg + 8'd1;
          round_reg <= round_reg + 8'd1;
          if ((round_reg + 8'd1) == 8'(ROUNDS)) begin
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            game_over_reg <= 1'b1;
          end else begin
            state_reg <= GAP;
            timer_reg <= '0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mole_led   = mole_led_reg;
  assign bus.score      = score_reg;
  assign bus.round      = round_reg;
  assign bus.hit_pulse  = hit_reg;
  assign bus.miss_pulse = miss_reg;
  assign bus.busy       = busy_reg;
  assign bus.game_over  = game_over_reg;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl: table of per-round scenarios plus
// hand-written idle, start-ignored and mid-round reset sequences.
module tb_mole_game_ctrl;
  localparam int N_MOLES     = 4;
  localparam int SHOW_CYCLES = 8;
  localparam int GAP_CYCLES  = 4;
  localparam int ROUNDS      = 3;

  typedef enum int {M_NONE, M_LIT2, M_WRONG, M_LITPLUS, M_LITLAST, M_HOLD, M_START} mode_t;

  typedef struct {
    bit    new_game;
    mode_t mode;
    bit    exp_hit;
    int    exp_score;
    int    exp_round;
    bit    exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] mdl_lfsr;

  mole_game_if #(.N_MOLES(N_MOLES)) bus ();

  mole_game_ctrl #(
    .N_MOLES(N_MOLES), .SHOW_CYCLES(SHOW_CYCLES),
    .GAP_CYCLES(GAP_CYCLES), .ROUNDS(ROUNDS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Reference LFSR, reseeded by the same reset as the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl_lfsr <= 8'hA5;
    else        mdl_lfsr <= lfsr_step(mdl_lfsr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic start_game;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_score", bus.score, 0);
    chk("start_round", bus.round, 0);
    chk("start_game_over", bus.game_over, 0);
  endtask

  // Entered at the first GAP cycle; leaves at the cycle after SCORE.
  task automatic run_round(input mode_t md, input bit exp_hit, input int exp_score,
                           input int exp_round, input bit exp_done);
    logic [7:0] l;
    logic [3:0] lit, wrong, pat;
    int press_at;
    l = mdl_lfsr;
    for (int i = 0; i < GAP_CYCLES - 1; i++) l = lfsr_step(l);
    lit   = 4'b0001 << l[1:0];
    wrong = {lit[2:0], lit[3]};
    press_at = -1;
    pat = 4'b0000;
    case (md)
      M_LIT2:    begin press_at = 1;               pat = lit;         end
      M_WRONG:   begin press_at = 1;               pat = wrong;       end
      M_LITPLUS: begin press_at = 1;               pat = lit | wrong; end
      M_LITLAST: begin press_at = SHOW_CYCLES - 1; pat = lit;         end
      default:   begin press_at = -1;              pat = 4'b0000;     end
    endcase
    if (md == M_HOLD) bus.whack = lit;

    for (int g = 0; g < GAP_CYCLES; g++) begin
      chk("gap_busy", bus.busy, 1);
      chk("gap_led", bus.mole_led, 0);
      tick();
    end
    for (int s = 0; s < SHOW_CYCLES; s++) begin
      chk("show_led", bus.mole_led, lit);
      chk("show_pulses", {bus.hit_pulse, bus.miss_pulse}, 0);
      if (md == M_START) bus.start = (s == 1);
      if (s == press_at) bus.whack = pat;
      tick();
      if (s == press_at) break;
    end
    bus.start = 1'b0;
    chk("score_hit", bus.hit_pulse, exp_hit);
    chk("score_miss", bus.miss_pulse, !exp_hit);
    chk("score_led", bus.mole_led, 0);
    bus.whack = 4'b0000;
    tick();
    chk("post_pulses", {bus.hit_pulse, bus.miss_pulse}, 0);
    chk("post_score", bus.score, exp_score);
    chk("post_round", bus.round, exp_round);
    chk("post_game_over", bus.game_over, exp_done);
    chk("post_busy", bus.busy, !exp_done);
    $display("round mode=%s lit=%b hit=%0b score=%0d round=%0d done=%0b",
             md.name(), lit, exp_hit, bus.score, bus.round, bus.game_over);
  endtask

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, M_NONE,    0, 0, 1, 0};
    vecs[1]  = '{0, M_NONE,    0, 0, 2, 0};
    vecs[2]  = '{0, M_NONE,    0, 0, 3, 1};
    vecs[3]  = '{1, M_LIT2,    1, 1, 1, 0};
    vecs[4]  = '{0, M_LIT2,    1, 2, 2, 0};
    vecs[5]  = '{0, M_LIT2,    1, 3, 3, 1};
    vecs[6]  = '{1, M_WRONG,   0, 0, 1, 0};
    vecs[7]  = '{0, M_LITPLUS, 0, 0, 2, 0};
    vecs[8]  = '{0, M_LITLAST, 1, 1, 3, 1};
    vecs[9]  = '{1, M_HOLD,    0, 0, 1, 0};
    vecs[10] = '{0, M_START,   0, 0, 2, 0};
    vecs[11] = '{0, M_NONE,    0, 0, 3, 1};
    vecs[12] = '{1, M_LIT2,    1, 1, 1, 0};

    bus.start = 1'b0;
    bus.whack = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", bus.mole_led, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_round", bus.round, 0);
    chk("rst_flags", {bus.busy, bus.game_over, bus.hit_pulse, bus.miss_pulse}, 0);
    rst_n = 1'b1;

    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_led", bus.mole_led, 0);
      chk("idle_score", bus.score, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_game_over", bus.game_over, 0);
    end
    $display("idle: 20 cycles without start");

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].new_game) start_game();
      run_round(vecs[v].mode, vecs[v].exp_hit, vecs[v].exp_score,
                vecs[v].exp_round, vecs[v].exp_done);
    end

    // Reset in the SHOW phase of the second round while score is 1.
    repeat (GAP_CYCLES) tick();
    chk("r2_show_lit", (bus.mole_led != 4'b0000), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", bus.mole_led, 0);
    chk("async_rst_score", bus.score, 0);
    chk("async_rst_round", bus.round, 0);
    chk("async_rst_flags", {bus.busy, bus.game_over, bus.hit_pulse, bus.miss_pulse}, 0);
    $display("reset asserted mid-round");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_pulses", {bus.hit_pulse, bus.miss_pulse}, 0);
    end
    start_game();
    run_round(M_LIT2, 1, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
